// File: rtl/memr_stream_reader.sv
// memr_stream_reader: walks consecutive memory words from a base address and streams them over valid/ready
module memr_stream_reader #(
    parameter int element_width = 64,
    parameter int no_of_units   = 8,
    parameter int address_width = 20,
    parameter int memory_depth  = 1001
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   start,
    input  logic [address_width-1:0]               base_address,
    input  logic [address_width-1:0]               vector_length,
    output logic [address_width-1:0]               mem_read_address,
    input  logic [no_of_units*element_width-1:0]   mem_data,
    output logic [no_of_units*element_width-1:0]   out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   finish
);
    localparam int dw = no_of_units * element_width;
    localparam logic [address_width-1:0] last_addr = address_width'(memory_depth - 1);
    localparam logic [address_width-1:0] one = address_width'(1);

    typedef enum logic [1:0] {idle, stream, drain, done} state_t;

    state_t                   state, state_nx;
    logic [address_width-1:0] remaining;
    logic [dw-1:0]            buf_data [2];
    logic [1:0]               buf_last;
    logic                     rd_ptr, wr_ptr;
    logic [1:0]               count;
    logic                     pop, issue;

    assign out_valid = count != 2'd0;
    assign pop       = out_valid & out_ready;
    assign issue     = (state == stream) && (count != 2'd2 || pop);
    assign out_data  = buf_data[rd_ptr];
    assign out_last  = buf_last[rd_ptr];
    assign busy      = state != idle;
    assign finish    = state == done;

    // next-state: stream until the final word is issued, then drain the buffer
    always_comb begin
        state_nx = state;
        case (state)
            idle:    if (start) state_nx = (vector_length == '0) ? done : stream;
            stream:  if (issue && remaining == one) state_nx = drain;
            drain:   if (count == 2'd1 && pop) state_nx = done;
            default: state_nx = idle;
        endcase
    end

    // state register plus read-address and remaining-length counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= idle;
            mem_read_address <= '0;
            remaining        <= '0;
        end else begin
            state <= state_nx;
            if (state == idle && start) begin
                mem_read_address <= base_address;
                remaining        <= vector_length;
            end else if (issue) begin
                mem_read_address <= (mem_read_address == last_addr) ? '0 : mem_read_address + one;
                remaining        <= remaining - one;
            end
        end
    end

    // two-entry output FIFO; every issued read lands here so stalls never re-read memory
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (issue) begin
                buf_data[wr_ptr] <= mem_data;
                buf_last[wr_ptr] <= remaining == one;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, issue} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_memr_stream_reader.sv
// tb_memr_stream_reader: vector table for exact latency plus model-checked directed and random transfers
module tb_memr_stream_reader;
    localparam int depth = 1001;

    logic         clk, reset_n, start, out_ready;
    logic [19:0]  base_address, vector_length, mem_read_address;
    logic [511:0] mem_data, out_data;
    logic         out_valid, out_last, busy, finish;
    int           checks = 0, passes = 0;

    memr_stream_reader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_address(base_address),
        .vector_length(vector_length), .mem_read_address(mem_read_address), .mem_data(mem_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .finish(finish)
    );

    function automatic logic [511:0] wd(input int k);
        logic [63:0] v;
        v = 64'(k);
        return {8{v}};
    endfunction

    assign mem_data = wd(int'(mem_read_address));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else passes++;
    endtask

    task automatic run_transfer(input int base, input int len, input int mode, input bit glitch);
        int  q[$];
        int  cyc, limit, e;
        bit  fin, rdy, prev_stall;
        logic [511:0] prev_data;
        for (int i = 0; i < len; i++) q.push_back((base + i) % depth);
        limit = (base + len <= depth - 1) ? base + len : depth - 1;
        start = 1;
        base_address = 20'(base);
        vector_length = 20'(len);
        @(negedge clk);
        start = 0;
        base_address = 20'($urandom);
        vector_length = 20'($urandom);
        cyc = 0;
        fin = 0;
        prev_stall = 0;
        prev_data = '0;
        while (!fin && cyc < 4 * len + 20) begin
            if (prev_stall) chk("stall_hold", out_data, prev_data);
            chk("addr_range", int'(mem_read_address) <= limit, 1'b1);
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom % 2);
            out_ready = rdy;
            start = glitch && cyc == 3;
            if (glitch && cyc == 3) base_address = 20'd500;
            if (out_valid && rdy) begin
                e = (q.size() != 0) ? q.pop_front() : -1;
                chk("word", out_data, wd(e));
                chk("last", out_last, q.size() == 0);
            end
            if (finish) begin
                fin = 1;
                chk("finish_empty", q.size(), 0);
                chk("finish_valid", out_valid, 1'b0);
                if (mode == 0) chk("finish_cycle", cyc, len + 1);
            end
            prev_stall = out_valid && !rdy;
            prev_data = out_data;
            @(negedge clk);
            cyc++;
        end
        start = 0;
        if (!fin) chk("finish_seen", 1'b0, 1'b1);
        chk("post_busy", busy, 1'b0);
        chk("post_finish", finish, 1'b0);
        out_ready = 1;
    endtask

    typedef struct {
        logic st;
        int   base;
        int   len;
        logic valid;
        int   k;
        logic last;
        logic fin;
        logic busy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 0, 4, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 0, 0, 1'b1, 1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 0, 0, 1'b1, 2, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 0, 0, 1'b1, 3, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 7, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        reset_n = 1;
        start = 0;
        out_ready = 0;
        base_address = 0;
        vector_length = 0;
        #2 reset_n = 0;
        #1;
        chk("rst_addr", mem_read_address, 0);
        chk("rst_data", out_data, 0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_finish", finish, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        out_ready = 1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].valid);
            if (tbl[i].valid) chk($sformatf("tbl%0d_data", i), out_data, wd(tbl[i].k));
            chk($sformatf("tbl%0d_last", i), out_last & out_valid, tbl[i].last);
            chk($sformatf("tbl%0d_finish", i), finish, tbl[i].fin);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            start = tbl[i].st;
            base_address = 20'(tbl[i].base);
            vector_length = 20'(tbl[i].len);
            @(negedge clk);
        end
        start = 0;
        run_transfer(10, 5, 1, 0);
        run_transfer(999, 4, 0, 0);
        run_transfer(0, 8, 0, 1);
        start = 1;
        base_address = 0;
        vector_length = 8;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_addr", mem_read_address, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_last", out_last, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_finish", finish, 1'b0);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        run_transfer(20, 2, 0, 0);
        for (int r = 0; r < 8; r++)
            run_transfer(int'($urandom_range(0, depth - 1)), int'($urandom_range(1, 12)), 2, 0);
        run_transfer(995, 9, 2, 0);
        run_transfer(1000, 1, 1, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
